sample_fifo: RTL and testbench

Parametrised single-clock FIFO buffering hydrophone ADC samples between the capture front end and the downstream processing/readout logic. It replaces the fixed 8-deep, pointer-only buffer with:
- configurable width and depth
- occupancy count, full and almost-full flags
- sticky overflow/underflow error flags
- an optional overwrite-oldest mode, so capture keeps the newest samples when the consumer stalls

Reads are first-word-fall-through.

---
 rtl/sample_fifo_if.sv | 28 ++
 rtl/sample_fifo.sv | 103 ++++++++++
 tb/tb_sample_fifo.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/sample_fifo_if.sv
// Handshake/status bundle between a sample producer/consumer and sample_fifo.
// master drives requests and data; slave is the FIFO itself.
interface sample_fifo_if #(
   parameter int unsigned DATA_W     = 24,
   parameter int unsigned DEPTH_LOG2 = 3
);
   logic                  wr_en;
   logic [DATA_W-1:0]     data_in;
   logic                  rd_en;
   logic                  clr_flags;
   logic [DATA_W-1:0]     data_out;
   logic                  empty;
   logic                  full;
   logic                  almost_full;
   logic [DEPTH_LOG2:0]   count;
   logic                  overflow;
   logic                  underflow;

   modport master (
      output wr_en, data_in, rd_en, clr_flags,
      input  data_out, empty, full, almost_full, count, overflow, underflow
   );

   modport slave (
      input  wr_en, data_in, rd_en, clr_flags,
      output data_out, empty, full, almost_full, count, overflow, underflow
   );
endinterface

// File: rtl/sample_fifo.sv
// First-word-fall-through sample FIFO with occupancy/status flags, sticky
// overflow/underflow and optional overwrite-oldest behaviour when full.
module sample_fifo #(
   parameter int unsigned DATA_W       = 24,
   parameter int unsigned DEPTH_LOG2   = 3,
   parameter int unsigned AFULL_THRESH = (2 ** DEPTH_LOG2) - 2,
   parameter int unsigned OVERWRITE    = 0
) (
   input  logic          clk,
   input  logic          rst,
   sample_fifo_if.slave  bus
);

   localparam int unsigned Depth = 2 ** DEPTH_LOG2;
   localparam logic [DEPTH_LOG2:0]   FullCnt  = (DEPTH_LOG2 + 1)'(Depth);
   localparam logic [DEPTH_LOG2:0]   AfullCnt = (DEPTH_LOG2 + 1)'(AFULL_THRESH);
   localparam logic [DEPTH_LOG2:0]   CntOne   = (DEPTH_LOG2 + 1)'(1);
   localparam logic [DEPTH_LOG2-1:0] PtrOne   = DEPTH_LOG2'(1);

   logic [DATA_W-1:0]     mem_q [Depth];
   logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
   logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
   logic [DEPTH_LOG2:0]   count_q, count_d;
   logic                  overflow_q, overflow_d;
   logic                  underflow_q, underflow_d;

   logic is_full, is_empty;
   logic wr_do, rd_do, ovf_evt, unf_evt;

   assign is_full  = (count_q == FullCnt);
   assign is_empty = (count_q == '0);

   always_comb begin
      wr_do   = 1'b0;
      rd_do   = 1'b0;
      ovf_evt = 1'b0;
      unf_evt = 1'b0;
      case ({bus.wr_en, bus.rd_en})
         2'b10: begin
            if (!is_full) begin
               wr_do = 1'b1;
            end else begin
               ovf_evt = 1'b1;
               // Overwrite mode discards the oldest word to make room.
               if (OVERWRITE != 0) begin
                  wr_do = 1'b1;
                  rd_do = 1'b1;
               end
            end
         end
         2'b01: begin
            if (!is_empty) rd_do = 1'b1;
            else           unf_evt = 1'b1;
         end
         2'b11: begin
            wr_do = 1'b1;
            if (is_empty) unf_evt = 1'b1;
            else          rd_do = 1'b1;
         end
         default: ;
      endcase
   end

   always_comb begin
      wr_ptr_d    = wr_do ? wr_ptr_q + PtrOne : wr_ptr_q;
      rd_ptr_d    = rd_do ? rd_ptr_q + PtrOne : rd_ptr_q;
      count_d     = count_q;
      if (wr_do && !rd_do) count_d = count_q + CntOne;
      if (rd_do && !wr_do) count_d = count_q - CntOne;
      overflow_d  = (overflow_q  & ~bus.clr_flags) | ovf_evt;
      underflow_d = (underflow_q & ~bus.clr_flags) | unf_evt;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
      end
   end

   // Storage is deliberately unreset; data_out is gated by count instead.
   always_ff @(posedge clk) begin
      if (wr_do) mem_q[wr_ptr_q] <= bus.data_in;
   end

   assign bus.data_out    = is_empty ? '0 : mem_q[rd_ptr_q];
   assign bus.empty       = is_empty;
   assign bus.full        = is_full;
   assign bus.almost_full = (count_q >= AfullCnt);
   assign bus.count       = count_q;
   assign bus.overflow    = overflow_q;
   assign bus.underflow   = underflow_q;

endmodule

// File: tb/tb_sample_fifo.sv
// Directed plus randomized checks of sample_fifo (drop, overwrite, 4-deep)
// against a queue-based reference model.
module tb_sample_fifo;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        wr_en = 1'b0;
   logic        rd_en = 1'b0;
   logic        clr_flags = 1'b0;
   logic [23:0] data_in = '0;

   always #5 clk = ~clk;

   sample_fifo_if #(.DATA_W(24), .DEPTH_LOG2(3)) if0 ();
   sample_fifo_if #(.DATA_W(24), .DEPTH_LOG2(3)) if1 ();
   sample_fifo_if #(.DATA_W(24), .DEPTH_LOG2(2)) if2 ();

   assign if0.wr_en = wr_en;  assign if0.rd_en = rd_en;
   assign if0.data_in = data_in;  assign if0.clr_flags = clr_flags;
   assign if1.wr_en = wr_en;  assign if1.rd_en = rd_en;
   assign if1.data_in = data_in;  assign if1.clr_flags = clr_flags;
   assign if2.wr_en = wr_en;  assign if2.rd_en = rd_en;
   assign if2.data_in = data_in;  assign if2.clr_flags = clr_flags;

   sample_fifo #(.DATA_W(24), .DEPTH_LOG2(3), .AFULL_THRESH(6), .OVERWRITE(0)) u_drop (
      .clk (clk), .rst (rst), .bus (if0)
   );
   sample_fifo #(.DATA_W(24), .DEPTH_LOG2(3), .AFULL_THRESH(6), .OVERWRITE(1)) u_ovw (
      .clk (clk), .rst (rst), .bus (if1)
   );
   sample_fifo #(.DATA_W(24), .DEPTH_LOG2(2), .AFULL_THRESH(2), .OVERWRITE(0)) u_d4 (
      .clk (clk), .rst (rst), .bus (if2)
   );

   // Observed outputs of the DUT under test in the current phase.
   int          sel = 0;
   logic [31:0] o_cnt, o_dout;
   logic        o_empty, o_full, o_afull, o_ovf, o_unf;

   always_comb begin
      o_cnt = 32'(if0.count); o_dout = 32'(if0.data_out); o_empty = if0.empty;
      o_full = if0.full; o_afull = if0.almost_full; o_ovf = if0.overflow; o_unf = if0.underflow;
      if (sel == 1) begin
         o_cnt = 32'(if1.count); o_dout = 32'(if1.data_out); o_empty = if1.empty;
         o_full = if1.full; o_afull = if1.almost_full; o_ovf = if1.overflow;
         o_unf = if1.underflow;
      end else if (sel == 2) begin
         o_cnt = 32'(if2.count); o_dout = 32'(if2.data_out); o_empty = if2.empty;
         o_full = if2.full; o_afull = if2.almost_full; o_ovf = if2.overflow;
         o_unf = if2.underflow;
      end
   end

   // Reference model: the FIFO contents as a queue plus sticky flags.
   logic [23:0] mq[$];
   int          m_depth = 8;
   int          m_thr = 6;
   bit          m_ow = 0;
   bit          m_ovf = 0;
   bit          m_unf = 0;

   int n_checks = 0;
   int n_pass = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s dut=%0d sel=%0d observed=0x%0h expected=0x%0h",
                  tag, sel, sel, obs, exp);
   endtask

   task automatic check_all(input string tag);
      int sz;
      sz = mq.size();
      chk({tag, ":count"}, o_cnt, 32'(sz));
      chk({tag, ":empty"}, 32'(o_empty), 32'(sz == 0));
      chk({tag, ":full"}, 32'(o_full), 32'(sz == m_depth));
      chk({tag, ":afull"}, 32'(o_afull), 32'(sz >= m_thr));
      chk({tag, ":dout"}, o_dout, (sz == 0) ? 32'd0 : 32'(mq[0]));
      chk({tag, ":ovf"}, 32'(o_ovf), 32'(m_ovf));
      chk({tag, ":unf"}, 32'(o_unf), 32'(m_unf));
   endtask

   task automatic model_step(input bit w, input bit r, input bit clr, input logic [23:0] d);
      bit full_now, empty_now, ne_ovf, ne_unf;
      full_now  = (mq.size() == m_depth);
      empty_now = (mq.size() == 0);
      ne_ovf = 0;
      ne_unf = 0;
      if (w && r) begin
         if (empty_now) ne_unf = 1;
         else void'(mq.pop_front());
         mq.push_back(d);
      end else if (w) begin
         if (!full_now) mq.push_back(d);
         else begin
            ne_ovf = 1;
            if (m_ow) begin
               void'(mq.pop_front());
               mq.push_back(d);
            end
         end
      end else if (r) begin
         if (empty_now) ne_unf = 1;
         else void'(mq.pop_front());
      end
      m_ovf = (m_ovf && !clr) || ne_ovf;
      m_unf = (m_unf && !clr) || ne_unf;
   endtask

   task automatic step(input string tag, input bit w, input bit r, input bit clr,
                       input logic [23:0] d);
      wr_en = w; rd_en = r; clr_flags = clr; data_in = d;
      @(posedge clk);
      model_step(w, r, clr, d);
      #1;
      check_all(tag);
      wr_en = 0; rd_en = 0; clr_flags = 0;
   endtask

   task automatic do_reset(input string tag);
      rst = 1'b1;
      #1;
      mq.delete();
      m_ovf = 0;
      m_unf = 0;
      check_all(tag);
      rst = 1'b0;
      #1;
   endtask

   task automatic rand_phase(input string tag, input int n);
      for (int i = 0; i < n; i++) begin
         step(tag, ($urandom_range(0, 99) < 55), ($urandom_range(0, 99) < 45),
              ($urandom_range(0, 99) < 8), 24'($urandom));
      end
   endtask

   initial begin
      // ---- Drop mode, DEPTH=8, AFULL_THRESH=6 ----
      sel = 0; m_depth = 8; m_thr = 6; m_ow = 0;
      @(posedge clk); #1;
      do_reset("reset0");
      for (int i = 1; i <= 8; i++) step("fill", 1, 0, 0, 24'(i));
      step("drop_aa", 1, 0, 0, 24'h0000AA);
      for (int i = 0; i < 8; i++) step("drain", 0, 1, 0, 24'h0);
      step("clr", 0, 0, 1, 24'h0);
      for (int i = 1; i <= 8; i++) step("refill", 1, 0, 0, 24'(i + 16));
      step("wr_rd_full", 1, 1, 0, 24'h000055);
      for (int i = 0; i < 8; i++) step("drain55", 0, 1, 0, 24'h0);
      step("wr_rd_empty", 1, 1, 0, 24'h000077);
      step("read77", 0, 1, 0, 24'h0);
      step("clr_alone", 0, 0, 1, 24'h0);
      step("rd_empty", 0, 1, 0, 24'h0);
      step("clr_plus_rd", 0, 1, 1, 24'h0);
      step("clr2", 0, 0, 1, 24'h0);
      for (int i = 1; i <= 5; i++) step("fill5", 1, 0, 0, 24'(i + 32));
      do_reset("async_rst");
      rand_phase("rand_drop", 300);

      // ---- Overwrite mode ----
      sel = 1; m_ow = 1;
      do_reset("reset1");
      for (int i = 1; i <= 10; i++) step("ow_fill", 1, 0, 0, 24'(i));
      for (int i = 0; i < 8; i++) step("ow_drain", 0, 1, 0, 24'h0);
      rand_phase("rand_ow", 300);

      // ---- DEPTH=4 wrap-around ----
      sel = 2; m_depth = 4; m_thr = 2; m_ow = 0;
      do_reset("reset2");
      step("wrap_w0", 1, 0, 0, 24'h100);
      for (int i = 1; i < 20; i++) begin
         case (i % 4)
            1:       step("wrap_w", 1, 0, 0, 24'(i + 256));
            3:       step("wrap_r", 0, 1, 0, 24'h0);
            default: step("wrap_wr", 1, 1, 0, 24'(i + 256));
         endcase
      end
      while (mq.size() > 0) step("wrap_drain", 0, 1, 0, 24'h0);
      rand_phase("rand_d4", 300);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
